// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types and constants for the memory-stage bus and its SRAM responder.
package dbus_sram_responder_pkg;

    localparam int unsigned DBUS_LATENCY_MAX = 15;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef logic [7:0] strobe_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        strobe_t     strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    // A request is a write as soon as any byte lane is enabled.
    function automatic logic strobe_is_write(strobe_t s);
        return s != '0;
    endfunction

endpackage

// File: rtl/dbus_sram_responder_sram_bytewrite.sv
// DEPTH x 64-bit SRAM: one registered read port, one byte-strobed write port.
// The read register can load zero instead of the array word, which the
// responder uses for out-of-range reads; it holds between reads.
module dbus_sram_responder_sram_bytewrite
    import dbus_sram_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rd_en_i,
    input  logic                       rd_clr_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
    output logic [63:0]                rd_data_o,
    input  logic                       wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]   wr_idx_i,
    input  strobe_t                    wr_strobe_i,
    input  logic [63:0]                wr_data_i
);

    logic [63:0] mem_q [DEPTH];
    logic [63:0] rd_data_q;

    // Byte-lane write; array contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (wr_en_i && wr_strobe_i[i]) begin
                mem_q[wr_idx_i][8*i +: 8] <= wr_data_i[8*i +: 8];
            end
        end
    end

    // Registered read, only updated when a read is requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_clr_i ? 64'h0 : mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus responder: accepts one request at a time and answers after a fixed
// LATENCY from a byte-writable SRAM mapped at BASE.
//
//   state  | meaning
//   IDLE   | addr_ok follows valid; a valid request is captured here
//   WAIT   | latency counter running down, request held in pending regs
//   RESP   | data_ok high for this one cycle; write commits at its end
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned LATENCY = 2,
    parameter logic [63:0] BASE    = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  dbus_req_t   dreq,
    output dbus_resp_t  dresp,
    output logic [31:0] done_cnt
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_WAIT   = 2'd1;
    localparam logic [1:0]  S_RESP   = 2'd2;
    localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
    logic             pend_inr_q, pend_inr_d;
    logic             pend_wr_q, pend_wr_d;
    strobe_t          pend_strobe_q, pend_strobe_d;
    logic [63:0]      pend_data_q, pend_data_d;
    logic [31:0]      done_cnt_q, done_cnt_d;

    logic [63:0]      req_off;
    logic             req_inr;
    logic [IDX_W-1:0] req_idx;
    logic             rd_en;
    logic             rd_clr;
    logic [IDX_W-1:0] rd_idx;
    logic             wr_en;
    logic [63:0]      rd_data;
    logic             unused_bits;

    assign req_off = dreq.addr - BASE;
    assign req_inr = (dreq.addr >= BASE) && (req_off[63:IDX_W+3] == '0);
    assign req_idx = req_off[IDX_W+2:3];

    // Size is not used for masking and the low address bits select nothing.
    assign unused_bits = ^{dreq.size, req_off[2:0]};

    // Next-state, capture and read-launch decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_idx_d    = pend_idx_q;
        pend_inr_d    = pend_inr_q;
        pend_wr_d     = pend_wr_q;
        pend_strobe_d = pend_strobe_q;
        pend_data_d   = pend_data_q;
        done_cnt_d    = done_cnt_q;
        rd_en         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dreq.valid) begin
                    pend_idx_d    = req_idx;
                    pend_inr_d    = req_inr;
                    pend_wr_d     = strobe_is_write(dreq.strobe);
                    pend_strobe_d = dreq.strobe;
                    pend_data_d   = dreq.data;
                    cnt_d         = LAT_LOAD;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        rd_en   = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    rd_en   = 1'b1;
                end
            end
            S_RESP: begin
                state_d    = S_IDLE;
                done_cnt_d = done_cnt_q + 32'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // With LATENCY==1 the read launches from IDLE before the pending regs load.
    assign rd_idx = (state_q == S_IDLE) ? req_idx  : pend_idx_q;
    assign rd_clr = (state_q == S_IDLE) ? !req_inr : !pend_inr_q;
    assign wr_en  = (state_q == S_RESP) && pend_wr_q && pend_inr_q && !reset;

    // State, counter and pending-request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            pend_idx_q    <= '0;
            pend_inr_q    <= 1'b0;
            pend_wr_q     <= 1'b0;
            pend_strobe_q <= '0;
            pend_data_q   <= '0;
            done_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_idx_q    <= pend_idx_d;
            pend_inr_q    <= pend_inr_d;
            pend_wr_q     <= pend_wr_d;
            pend_strobe_q <= pend_strobe_d;
            pend_data_q   <= pend_data_d;
            done_cnt_q    <= done_cnt_d;
        end
    end

    dbus_sram_responder_sram_bytewrite #(
        .DEPTH(DEPTH)
    ) u_sram (
        .clk        (clk),
        .reset      (reset),
        .rd_en_i    (rd_en),
        .rd_clr_i   (rd_clr),
        .rd_idx_i   (rd_idx),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_idx_i   (pend_idx_q),
        .wr_strobe_i(pend_strobe_q),
        .wr_data_i  (pend_data_q)
    );

    assign dresp.addr_ok = (state_q == S_IDLE) && dreq.valid;
    assign dresp.data_ok = (state_q == S_RESP);
    assign dresp.data    = rd_data;
    assign done_cnt      = done_cnt_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: three instances (LATENCY 1, 2, 4) checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_dbus_sram_responder;
    import dbus_sram_responder_pkg::*;

    localparam int          NI    = 3;
    localparam int          DEPTH = 4096;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset    [NI];
    dbus_req_t   dreq     [NI];
    dbus_resp_t  dresp    [NI];
    logic [31:0] done_cnt [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dbus_sram_responder #(
            .DEPTH  (DEPTH),
            .LATENCY((g == 0) ? 1 : ((g == 1) ? 2 : 4)),
            .BASE   (BASE)
        ) u_dut (
            .clk     (clk),
            .reset   (reset[g]),
            .dreq    (dreq[g]),
            .dresp   (dresp[g]),
            .done_cnt(done_cnt[g])
        );
    end

    // Reference model state: memory image, outstanding transaction, counters.
    logic [63:0] m_mem   [NI][DEPTH];
    bit          m_known [NI][DEPTH];
    bit          m_busy  [NI];
    int          m_ok    [NI];
    bit          m_inr   [NI];
    int          m_idx   [NI];
    logic [7:0]  m_str   [NI];
    logic [63:0] m_dat   [NI];
    logic [31:0] m_cnt   [NI];
    logic [63:0] m_last  [NI];
    bit          m_lknown[NI];
    logic        obs_dok [NI];
    logic [63:0] obs_data[NI];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    function automatic int lat_of(int g);
        case (g)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    task automatic check(int g, string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst %0d cycle %0d: got %h, expected %h", name, g, cyc, act, exp);
        end
    endtask

    // Compare one instance's outputs for this cycle, then advance the model past the edge.
    task automatic model_step(int g);
        logic        exp_dok;
        logic [63:0] off;
        obs_dok[g]  = dresp[g].data_ok;
        obs_data[g] = dresp[g].data;
        if (reset[g]) begin
            m_busy[g]   = 0;
            m_cnt[g]    = '0;
            m_last[g]   = '0;
            m_lknown[g] = 1;
            return;
        end
        exp_dok = m_busy[g] && (cyc == m_ok[g]);
        check(g, "addr_ok",  64'(dresp[g].addr_ok), 64'(!m_busy[g] && dreq[g].valid));
        check(g, "data_ok",  64'(dresp[g].data_ok), 64'(exp_dok));
        check(g, "done_cnt", 64'(done_cnt[g]),      64'(m_cnt[g]));
        if (exp_dok) begin
            if (!m_inr[g]) begin
                m_last[g]   = 64'h0;
                m_lknown[g] = 1;
            end else begin
                m_last[g]   = m_mem[g][m_idx[g]];
                m_lknown[g] = m_known[g][m_idx[g]];
            end
        end
        if (m_lknown[g]) check(g, "data", dresp[g].data, m_last[g]);
        if (exp_dok) begin
            if (m_inr[g] && m_str[g] != 8'h00) begin
                for (int i = 0; i < 8; i++)
                    if (m_str[g][i]) m_mem[g][m_idx[g]][8*i +: 8] = m_dat[g][8*i +: 8];
                if (m_str[g] == 8'hFF) m_known[g][m_idx[g]] = 1;
            end
            m_cnt[g]  = m_cnt[g] + 32'd1;
            m_busy[g] = 0;
        end else if (!m_busy[g] && dreq[g].valid) begin
            off       = dreq[g].addr - BASE;
            m_inr[g]  = (dreq[g].addr >= BASE) && (off < 64'(8 * DEPTH));
            m_idx[g]  = int'(off / 8);
            m_str[g]  = dreq[g].strobe;
            m_dat[g]  = dreq[g].data;
            m_busy[g] = 1;
            m_ok[g]   = cyc + lat_of(g);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int g = 0; g < NI; g++) model_step(g);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(int g);
        dreq[g].valid = 1'b0;
        reset[g] = 1'b1;
        tick();
        tick();
        reset[g] = 1'b0;
    endtask

    // Present a request and wait (bounded) for data_ok; optionally keep valid high afterwards.
    task automatic issue(input int g, input logic [63:0] a, input logic [7:0] s,
                         input logic [63:0] d, input bit hold,
                         output int lat, output logic [63:0] rd, output int okc);
        dreq[g].valid  = 1'b1;
        dreq[g].addr   = a;
        dreq[g].size   = MSIZE8;
        dreq[g].strobe = s;
        dreq[g].data   = d;
        lat = -1;
        rd  = '0;
        okc = -1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (obs_dok[g]) begin
                lat = n;
                rd  = obs_data[g];
                okc = cyc - 1;
                break;
            end
        end
        if (lat < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout inst %0d: no data_ok within 40 cycles, required one", g);
        end
        if (!hold) dreq[g].valid = 1'b0;
    endtask

    function automatic logic [63:0] rnd_addr();
        int unsigned r;
        logic [63:0] a;
        r = $urandom_range(0, 9);
        if (r == 0)      a = BASE - 64'(8 * $urandom_range(1, 4));
        else if (r == 1) a = BASE + 64'(8 * DEPTH) + 64'(8 * $urandom_range(0, 4));
        else if (r < 6)  a = BASE + 64'(8 * $urandom_range(0, 15));
        else             a = BASE + 64'(8 * (DEPTH - 1 - int'($urandom_range(0, 3))));
        a[2:0] = 3'($urandom_range(0, 7));
        return a;
    endfunction

    function automatic logic [7:0] rnd_strobe();
        int unsigned r;
        r = $urandom_range(0, 3);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'hFF;
        return 8'($urandom);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          okc;
        int          okv [4];
        int          idx;
        logic [63:0] rd;
        bit          saw;

        for (int g = 0; g < NI; g++) begin
            reset[g] = 1'b1;
            dreq[g]  = '0;
        end
        @(posedge clk);
        #1;
        tick();
        tick();
        for (int g = 0; g < NI; g++) reset[g] = 1'b0;
        for (int g = 0; g < NI; g++) check(g, "reset_done_cnt", 64'(done_cnt[g]), 64'd0);
        for (int g = 0; g < NI; g++) check(g, "reset_data", dresp[g].data, 64'h0);

        // Give each instance a known window at both ends of the array.
        for (int g = 0; g < NI; g++) begin
            for (int k = 0; k < 20; k++) begin
                idx = (k < 16) ? k : DEPTH - 20 + k;
                issue(g, BASE + 64'(idx * 8), 8'hFF, {$urandom, $urandom}, 0, lat, rd, okc);
            end
        end

        // Read after reset, LATENCY 2; SRAM contents survive reset.
        issue(1, BASE, 8'hFF, 64'h1122_3344_5566_7788, 0, lat, rd, okc);
        do_reset(1);
        issue(1, BASE, 8'h00, 64'h0, 0, lat, rd, okc);
        check(1, "read_latency", 64'(lat), 64'd2);
        check(1, "read_data", rd, 64'h1122_3344_5566_7788);
        check(1, "read_done_cnt", 64'(done_cnt[1]), 64'd1);

        // Byte-strobe write merges lanes 0..3 only.
        issue(1, BASE + 64'h8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, lat, rd, okc);
        issue(1, BASE + 64'h8, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 0, lat, rd, okc);
        issue(1, BASE + 64'h8, 8'h00, 64'h0, 0, lat, rd, okc);
        check(1, "strobe_merge", rd, 64'hFFFF_FFFF_CCCC_DDDD);
        check(1, "strobe_done_cnt", 64'(done_cnt[1]), 64'd4);

        // Out-of-range read returns zero on time; out-of-range write must not alias.
        issue(1, 64'h7FFF_FFF8, 8'h00, 64'h0, 0, lat, rd, okc);
        check(1, "oor_read_latency", 64'(lat), 64'd2);
        check(1, "oor_read_data", rd, 64'h0);
        issue(1, 64'h8000_8000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 0, lat, rd, okc);
        issue(1, BASE + 64'h8, 8'h00, 64'h0, 0, lat, rd, okc);
        check(1, "oor_word1_kept", rd, 64'hFFFF_FFFF_CCCC_DDDD);
        issue(1, BASE, 8'h00, 64'h0, 0, lat, rd, okc);
        check(1, "oor_word0_kept", rd, 64'h1122_3344_5566_7788);
        check(1, "oor_done_cnt", 64'(done_cnt[1]), 64'd8);

        // Back-to-back with valid held, LATENCY 1.
        do_reset(0);
        for (int k = 0; k < 4; k++) begin
            issue(0, BASE + 64'(8 * k), 8'h00, 64'h0, 1, lat, rd, okc);
            okv[k] = okc;
        end
        dreq[0].valid = 1'b0;
        check(0, "b2b_first_latency", 64'(lat), 64'd1);
        for (int k = 1; k < 4; k++) check(0, "b2b_spacing", 64'(okv[k] - okv[0]), 64'(2 * k));
        check(0, "b2b_done_cnt", 64'(done_cnt[0]), 64'd4);

        // Reset while a write waits, LATENCY 4.
        issue(2, BASE + 64'h10, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, lat, rd, okc);
        do_reset(2);
        dreq[2].valid  = 1'b1;
        dreq[2].addr   = BASE + 64'h10;
        dreq[2].strobe = 8'hFF;
        dreq[2].data   = 64'hFEDC_BA98_7654_3210;
        tick();
        dreq[2].valid = 1'b0;
        tick();
        reset[2] = 1'b1;
        tick();
        reset[2] = 1'b0;
        saw = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (obs_dok[2]) saw = 1;
        end
        check(2, "midreset_no_data_ok", 64'(saw), 64'd0);
        check(2, "midreset_done_cnt", 64'(done_cnt[2]), 64'd0);
        issue(2, BASE + 64'h10, 8'h00, 64'h0, 0, lat, rd, okc);
        check(2, "midreset_latency", 64'(lat), 64'd4);
        check(2, "midreset_word_kept", rd, 64'h0123_4567_89AB_CDEF);
        check(2, "midreset_done_after", 64'(done_cnt[2]), 64'd1);

        // Completion counter wraps.
        force g_dut[1].u_dut.done_cnt_q = 32'hFFFF_FFFF;
        m_cnt[1] = 32'hFFFF_FFFF;
        #1;
        release g_dut[1].u_dut.done_cnt_q;
        check(1, "forced_cnt", 64'(done_cnt[1]), 64'hFFFF_FFFF);
        issue(1, BASE, 8'h00, 64'h0, 0, lat, rd, okc);
        check(1, "wrap_done_cnt", 64'(done_cnt[1]), 64'd0);

        // Random traffic, including mid-transaction request changes and held valid.
        for (int g = 0; g < NI; g++) begin
            for (int t = 0; t < 60; t++) begin
                dreq[g].valid  = 1'b1;
                dreq[g].addr   = rnd_addr();
                dreq[g].strobe = rnd_strobe();
                dreq[g].data   = {$urandom, $urandom};
                saw = 0;
                for (int n = 0; n < 40; n++) begin
                    tick();
                    if (obs_dok[g]) begin
                        saw = 1;
                        break;
                    end
                    if ($urandom_range(0, 3) == 0) begin
                        dreq[g].addr   = rnd_addr();
                        dreq[g].strobe = rnd_strobe();
                        dreq[g].data   = {$urandom, $urandom};
                    end
                end
                if (!saw) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL random_timeout inst %0d: no data_ok within 40 cycles, required one", g);
                end
                if ($urandom_range(0, 1) == 0) begin
                    dreq[g].valid = 1'b0;
                    for (int n = 0; n < int'($urandom_range(0, 2)); n++) tick();
                end
            end
            dreq[g].valid = 1'b0;
            tick();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
